// File: rtl/keypad_scan_fifo.sv
// Matrix keypad front end: one-cold column sweep, two-flop row synchroniser,
// whole-sweep debounce with ghost rejection, and a key-code FIFO with sticky overflow.
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 8,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] key_col,
    input  logic [ROWS-1:0] key_row,
    output logic            key_valid,
    output logic [CW-1:0]   key_code,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow,
    input  logic            clr_ovf
);
    localparam int NK  = ROWS * COLS;
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int CIW = $clog2(COLS);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_KEY,
        CLS_MULTI
    } cls_t;

    logic [DW-1:0]   dwell;
    logic [CIW-1:0]  col_idx;
    logic [ROWS-1:0] row_s1;
    logic [ROWS-1:0] row_s2;
    logic [NK-1:0]   snap;
    logic [NK-1:0]   snap_next;
    logic            sample;
    logic            sweep_end;

    cls_t            cls_kind;
    logic            cls_is_key;
    logic [CW-1:0]   cls_code;

    logic            cand_key;
    logic [CW-1:0]   cand_code;
    logic [3:0]      stable_cnt;
    logic [3:0]      cnt_next;
    logic            deb_key;
    logic [CW-1:0]   deb_code;
    logic            accept;
    logic            push;

    logic [CW-1:0]   mem [FIFO_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            pop;
    logic            wr_en;
    logic            ovf_set;

    assign sample    = (dwell == DW'(SCAN_DIV - 1));
    assign sweep_end = sample && (col_idx == CIW'(COLS - 1));

    always_comb begin
        key_col = '1;
        for (int unsigned i = 0; i < COLS; i++)
            if (col_idx == CIW'(i)) key_col[i] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell   <= '0;
            col_idx <= '0;
            row_s1  <= '0;
            row_s2  <= '0;
            snap    <= '1;
        end else begin
            row_s1 <= key_row;
            row_s2 <= row_s1;
            if (sample) begin
                dwell   <= '0;
                col_idx <= (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
                snap    <= snap_next;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // The sweep-end classification must include the column being sampled this
    // cycle, so it works on the snapshot as it will look after this edge.
    always_comb begin
        snap_next = snap;
        for (int unsigned k = 0; k < NK; k++)
            if (CIW'(k % COLS) == col_idx) snap_next[k] = row_s2[k / COLS];

        cls_kind = CLS_NONE;
        cls_code = '0;
        for (int unsigned k = 0; k < NK; k++)
            if (!snap_next[k]) begin
                cls_kind = (cls_kind == CLS_NONE) ? CLS_KEY : CLS_MULTI;
                cls_code = CW'(k);
            end
    end

    assign cls_is_key = (cls_kind == CLS_KEY);

    always_comb begin
        cnt_next = 4'd1;
        if ((cls_is_key == cand_key) && (cls_code == cand_code))
            cnt_next = (stable_cnt >= 4'(DEBOUNCE)) ? stable_cnt : stable_cnt + 4'd1;
        accept = sweep_end && (cls_kind != CLS_MULTI) && (cnt_next == 4'(DEBOUNCE)) &&
                 ((cls_is_key != deb_key) || (cls_code != deb_code));
        push   = accept && cls_is_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_key   <= 1'b0;
            cand_code  <= '0;
            stable_cnt <= '0;
            deb_key    <= 1'b0;
            deb_code   <= '0;
        end else if (sweep_end && (cls_kind != CLS_MULTI)) begin
            cand_key   <= cls_is_key;
            cand_code  <= cls_code;
            stable_cnt <= cnt_next;
            if (accept) begin
                deb_key  <= cls_is_key;
                deb_code <= cls_code;
            end
        end
    end

    assign key_held = deb_key;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign key_valid = !empty;
    assign pop       = key_valid && key_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en     = push && (!full || pop);
    assign ovf_set   = push && full && !pop;
    assign key_code  = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= cls_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (PW + 1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (PW + 1)'(1);
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: doc/keypad_scan_fifo.md
# keypad_scan_fifo

Parametrised matrix-keypad front end for the FP MAC board, replacing the fixed 4x4 scan logic. The block drives the keypad columns one at a time, samples the rows through a two-stage synchroniser, and debounces over whole sweeps. It rejects ghosted multi-key snapshots and queues key-press codes in a small FIFO with a valid/ready pop interface. Downstream operand-entry logic consumes codes at its own pace; a sticky flag reports when codes are lost.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 8, clock cycles each column is held low (>= 4)
- DEBOUNCE, 3, consecutive identical sweeps required to accept a state (1..15)
- FIFO_DEPTH, 4, key-code FIFO entries (power of two, >= 2)
- CW, $clog2(ROWS*COLS), key-code width (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_col  out  COLS  column drive; active-low one-cold
- key_row  in  ROWS  row sense; active-low, externally pulled up
- key_valid  out  1  FIFO non-empty; key_code is valid
- key_code  out  CW  head code = row*COLS + col
- key_ready  in  1  pop; a pop occurs on a cycle where key_valid && key_ready
- key_held  out  1  debounced state is a single pressed key
- overflow  out  1  sticky; a press was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Reset values: key_col = all ones with bit 0 low; key_valid 0, key_code 0, key_held 0, overflow 0. All counters, the synchroniser and the FIFO pointers are 0. The debounced state is NONE.
- Scan: the dwell counter runs from 0 to SCAN_DIV-1. The column index advances on wrap and runs from 0 to COLS-1, then back to 0. key_col[i] is 0 only while the index equals i.
- The synchronised rows are sampled into the snapshot at dwell = SCAN_DIV-1. That sample sees rows that have been stable at least SCAN_DIV-3 cycles after the column change.
- Sweep end is the sample cycle of column COLS-1. The snapshot is classified as one of:
  - NONE: no bits low.
  - KEY(c): exactly one bit low; c = row*COLS + col.
  - MULTI: two or more bits low.
- MULTI sweeps do not change the candidate or the counter. They neither count toward a transition nor reset it.
- Debounce:
  - The candidate is compared with the previous sweep's class. If they are equal, the stable counter is incremented, saturating at DEBOUNCE. Otherwise the counter is set to 1.
  - When the counter reaches DEBOUNCE and the candidate differs from the debounced state, the debounced state takes the candidate.
  - A transition into KEY(c), from NONE or from a different key, pushes c into the FIFO.
  - Release (transition to NONE) pushes nothing.
  - key_held = (debounced state is KEY).
- FIFO behaviour:
  - A push when not full writes the entry.
  - A push when full with no pop in the same cycle drops the code and sets overflow.
  - A push and a pop in the same cycle when full both proceed; no overflow.
  - A pop when empty is ignored.
- key_code is the head entry. It is 0 when empty.
- overflow is cleared by clr_ovf. If a set and a clear occur in the same cycle, the set wins.
- Reset asserted mid-operation returns the block to the reset values immediately. FIFO contents are discarded.

## Timing
- Sweep period: COLS*SCAN_DIV cycles (32 at default parameters).
- Push occurs on the sweep-end cycle of the DEBOUNCE-th consecutive matching sweep.
- key_valid rises on the following clock edge. key_held rises on that same following edge.
- A pop on edge N updates key_code/key_valid after edge N (registered pointers, head read combinationally from storage).
- There is no timing dependence on key_ready during scanning; the scan never stalls.

## Test plan
- Reset: hold rst=0 for 3 cycles with random key_row -> key_col=1110, key_valid=0, overflow=0. After release, key_col walks 1110, 1101, 1011, 0111 and changes every 8 cycles.
- Single press: drive key_row=1101 only while key_col=1011, otherwise 1111 -> after 3 sweeps key_valid=1, key_code=6, key_held=1. With key_ready low, exactly one entry is present. Release for 3 sweeps -> key_held=0 and no new entry.
- Bounce: toggle the press every other sweep for 10 sweeps, then hold it -> no push until 3 stable sweeps; exactly one code 6 is queued.
- Ghosting: press rows 0 and 1 on column 2 together (key_row=1100 at col 2) -> no push and key_held unchanged. Then release row 0 and hold -> code 6 is pushed after 3 sweeps.
- Overflow: 5 distinct presses (codes 0, 5, 10, 15, 3) with key_ready=0 -> FIFO holds 0, 5, 10, 15 and overflow=1. Pop all four in order, then pulse clr_ovf -> overflow=0. A same-cycle push+pop on a full FIFO leaves overflow=0.
- Mid-scan reset: assert rst while a key is debounced and two codes are queued -> all outputs return to reset values within the same cycle, and the queued codes never appear.
